// File: rtl/mmc_cmd_seq.sv
// MMC/SD CMD-line sequencer: shifts out a 48-bit command frame one MMC clock at a time,
// then hunts for and captures a 48-bit response with CRC7/end-bit checks or a timeout.
module mmc_cmd_seq #(
  parameter int TIMEOUT_CLKS = 64,
  parameter int NCC_CLKS     = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic        abort,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [1:0]  resp_type,
  output logic        busy,
  output logic        done,
  output logic [5:0]  resp_index,
  output logic [31:0] resp_arg,
  output logic        crc_err,
  output logic        end_err,
  output logic        timeout,
  output logic        clk_tick,
  input  logic        clk_done,
  output logic        mmc_cmd_o,
  output logic        mmc_cmd_oe,
  input  logic        mmc_cmd_i
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_TX    = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RX    = 3'd3;
  localparam logic [2:0] S_TRAIL = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [6:0] TO_LAST  = 7'(TIMEOUT_CLKS - 1);
  localparam logic [6:0] NCC_LAST = 7'(NCC_CLKS - 1);

  // Serial CRC7, generator x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  logic [2:0]  state;
  logic [6:0]  cnt;
  logic [6:0]  crc;
  logic [46:0] tx_sr;
  logic [44:0] rx_sr;
  logic [1:0]  rtype_q;
  logic        has_resp;

  assign has_resp = (rtype_q == 2'd1) || (rtype_q == 2'd2);

  // NOTE: all state is updated with non-blocking assignments so every branch reads the
  // pre-edge values of cnt, crc and the shift registers regardless of statement order.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= S_IDLE;
      cnt        <= '0;
      crc        <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      rtype_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      clk_tick   <= 1'b0;
      mmc_cmd_o  <= 1'b1;
      mmc_cmd_oe <= 1'b0;
      resp_index <= '0;
      resp_arg   <= '0;
      crc_err    <= 1'b0;
      end_err    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      // NOTE: tick and done are single-cycle pulses; defaulting them low here means only
      // the branches that issue one need to mention them.
      clk_tick <= 1'b0;
      done     <= 1'b0;
      if (abort) begin
        state      <= S_IDLE;
        busy       <= 1'b0;
        mmc_cmd_oe <= 1'b0;
        mmc_cmd_o  <= 1'b1;
      end else if (start && !busy) begin
        state      <= S_TX;
        busy       <= 1'b1;
        mmc_cmd_oe <= 1'b1;
        mmc_cmd_o  <= 1'b0;
        clk_tick   <= 1'b1;
        cnt        <= '0;
        crc        <= '0;
        rtype_q    <= resp_type;
        tx_sr      <= {1'b1, cmd_index, cmd_arg, 7'd0, 1'b1};
        crc_err    <= 1'b0;
        end_err    <= 1'b0;
        timeout    <= 1'b0;
      end else if (state == S_DONE) begin
        state <= S_IDLE;
      end else if (clk_done && state != S_IDLE) begin
        case (state)
          S_TX: begin
            clk_tick <= 1'b1;
            if (cnt == 7'd47) begin
              mmc_cmd_oe <= 1'b0;
              mmc_cmd_o  <= 1'b1;
              cnt        <= '0;
              state      <= has_resp ? S_WAIT : S_TRAIL;
            end else begin
              cnt   <= cnt + 7'd1;
              tx_sr <= {tx_sr[45:0], 1'b0};
              if (cnt < 7'd40) begin
                crc       <= crc7_next(crc, mmc_cmd_o);
                mmc_cmd_o <= (cnt == 7'd39) ? crc7_next(crc, mmc_cmd_o) >> 6 != 7'd0
                                            : tx_sr[46];
              end else if (cnt < 7'd46) begin
                crc       <= {crc[5:0], 1'b0};
                mmc_cmd_o <= crc[5];
              end else begin
                mmc_cmd_o <= 1'b1;
              end
            end
          end
          S_WAIT: begin
            clk_tick <= 1'b1;
            if (!mmc_cmd_i) begin
              state <= S_RX;
              cnt   <= 7'd1;
              crc   <= '0;
              rx_sr <= '0;
            end else if (cnt == TO_LAST) begin
              timeout <= 1'b1;
              state   <= S_TRAIL;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
          S_RX: begin
            clk_tick <= 1'b1;
            rx_sr    <= {rx_sr[43:0], mmc_cmd_i};
            if (cnt < 7'd40) crc <= crc7_next(crc, mmc_cmd_i);
            // On the final bit, rx_sr still holds response bits 45..1 at [44:0].
            if (cnt == 7'd47) begin
              crc_err    <= (rtype_q == 2'd1) && (crc != rx_sr[6:0]);
              end_err    <= !mmc_cmd_i;
              resp_index <= rx_sr[44:39];
              resp_arg   <= rx_sr[38:7];
              state      <= S_TRAIL;
              cnt        <= '0;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
          S_TRAIL: begin
            if (cnt == NCC_LAST) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              cnt      <= cnt + 7'd1;
              clk_tick <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/mmc_cmd_seq.md
# mmc_cmd_seq

Command-line sequencer for the MMC/SD controller. It serialises a 48-bit MMC command frame (start bit, index, argument, CRC7, end bit) onto the CMD line one MMC clock at a time, and issues each clock as a tick/done handshake to the clock controller. It then hunts for and captures a 48-bit response with CRC7 and end-bit checking, or times out. Software sees a single start/done transaction in place of bit-banging the CMD line.

## Interface
- TIMEOUT_CLKS, 64: MMC clocks allowed between end of command and response start bit (Ncr).
- NCC_CLKS, 8: trailing MMC clocks issued with CMD released after each transaction.
- wb_clk_i  in  1  system clock; all logic is on its rising edge.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle request; accepted only when busy=0.
- abort  in  1  one-cycle; forces IDLE from any state.
- cmd_index  in  6  command index; sampled on accepted start.
- cmd_arg  in  32  command argument; sampled on accepted start.
- resp_type  in  2  0: no response; 1: 48-bit with CRC check (R1/R6/R7); 2: 48-bit without CRC check (R3); 3: treated as 0.
- busy  out  1  high from accepted start until the done pulse.
- done  out  1  one-cycle completion pulse.
- resp_index  out  6  captured response bits [45:40].
- resp_arg  out  32  captured response bits [39:8].
- crc_err  out  1  CRC7 mismatch (resp_type 1 only).
- end_err  out  1  response end bit was 0.
- timeout  out  1  no start bit within TIMEOUT_CLKS.
- clk_tick  out  1  one-cycle request for one MMC clock period.
- clk_done  in  1  one-cycle pulse at the MMC rising edge; the CMD line is sampled here.
- mmc_cmd_o  out  1  CMD drive value.
- mmc_cmd_oe  out  1  CMD output enable.
- mmc_cmd_i  in  1  CMD line input.

## Operation
- States: IDLE, TX, WAIT_START, RX, TRAIL, DONE.
- IDLE: mmc_cmd_o=1, oe=0. On start, latch the inputs, clear the status flags, set busy, and go to TX.
- TX: shift the 48-bit frame MSB-first: 0, 1, cmd_index, cmd_arg, crc7, 1. oe=1.
  - crc7 uses polynomial x^7+x^3+1, initial value 0, computed over the first 40 bits in parallel with shifting.
  - Per bit: present the bit, pulse clk_tick, wait for clk_done, then advance.
  - After bit 47's clk_done: go to WAIT_START if resp_type is 1 or 2, else TRAIL.
- WAIT_START: oe=0. Pulse clk_tick each period.
  - On a clk_done with mmc_cmd_i=0, that bit is response bit 47; go to RX.
  - After TIMEOUT_CLKS clk_done pulses without a 0, set timeout and go to TRAIL.
- RX: capture 47 more bits MSB-first into a 48-bit shift register.
  - Run a CRC7 over bits 47..8 and compare it with bits 7..1.
  - After bit 0: set crc_err on mismatch when resp_type=1; set end_err if bit 0 = 0.
  - Load resp_index and resp_arg, then go to TRAIL.
- TRAIL: oe=0. Issue NCC_CLKS clocks, then go to DONE.
- DONE: pulse done for one cycle, clear busy, return to IDLE.
- resp_index, resp_arg and the status flags hold until the next accepted start.
- clk_done outside a wait-for-done window is ignored.
- start while busy=1 is ignored.
- abort, in any state, next cycle:
  - Go to IDLE with oe=0, mmc_cmd_o=1, busy=0.
  - No done pulse; outputs are not updated.
  - abort has priority over a simultaneous start.
- Asynchronous reset mid-transaction has the same effect as abort and also clears all registers.

## Timing
- Reset values: busy=0, done=0, clk_tick=0, mmc_cmd_o=1, mmc_cmd_oe=0, resp_index=0, resp_arg=0, crc_err=0, end_err=0, timeout=0.
- Accepted start at cycle N:
  - busy=1, oe=1, mmc_cmd_o=0 (start bit) at N+1.
  - First clk_tick at N+1.
- mmc_cmd_o changes only in the cycle after a clk_done, and is stable before the next clk_tick.
- clk_tick is never re-asserted until the clk_done for the previous tick has arrived.
- Exactly one clk_tick is issued per MMC clock.
- Each transaction issues exactly this many clk_ticks:
  - No response: 48 + NCC_CLKS.
  - With response: 48 + k + 47 + NCC_CLKS, where k (1..TIMEOUT_CLKS) is the WAIT_START clock on which the start bit was seen.
  - Timeout: 48 + TIMEOUT_CLKS + NCC_CLKS.
- done is asserted one cycle after the last TRAIL clk_done. busy falls in the same cycle done is asserted.

## Test plan
- CMD0, arg 0, resp_type 0, instant clk_done model -> CMD bytes 0x40 00 00 00 00 95; 56 ticks; done with all flags 0.
- CMD8, arg 0x1AA, resp_type 1; card replies after 3 clocks with 0x08 00 00 01 AA 13 -> TX bytes 0x48 00 00 01 AA 87; resp_index=8, resp_arg=0x000001AA, crc_err=0, end_err=0; 48+3+47+8 ticks.
- Same as above but the response CRC byte is 0x15 -> crc_err=1. With resp_type=2 the same response -> crc_err=0.
- resp_type 1, CMD held high -> timeout=1 after 64 wait clocks; 48+64+8 ticks total; resp fields unchanged.
- abort during TX bit 20, with a simultaneous start -> next cycle: IDLE, oe=0, mmc_cmd_o=1, busy=0, no done. A following start sends a full, correct frame.
- start pulsed while busy, and clk_done pulses injected in IDLE -> no effect on the frame, tick count or status.
